clock_divider: RTL and testbench

- Synchronous programmable clock divider.
- Produces a divided, near-50%-duty output `clk_out` from the system clock `clk`, plus single-cycle strobes marking `clk_out` edges.
- Divide ratio defaults to 2 and can be changed at runtime; changes take effect glitch-free at a period boundary.
- Feeds slow peripherals and timing logic; `clk_out` is a registered signal, not a clock-tree primitive.

---
 rtl/clock_divider.sv | 123 ++++++++++++
 tb/tb_clock_divider.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider.sv
// ---------------------------------------------------------------------------
// clock_divider
//   Synchronous programmable clock divider. Generates a registered, near-50%
//   duty clock clk_out from clk, plus one-cycle strobes on its edges. The
//   divisor can be changed at runtime. A new divisor only takes effect at a
//   period boundary, so no period is ever truncated or stretched.
//
// Parameters
//   WIDTH        width of the divisor and of the internal counter
//   DEFAULT_DIV  divisor after reset (values below 2 behave as 2)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          count enable; when low all state holds and ticks are 0
//   div_load    one-cycle request to load div_value as the next divisor
//   div_value   requested divisor (0 and 1 are stored as 2)
//   clk_out     divided clock: low for N-floor(N/2) cycles, then high for
//               floor(N/2) cycles
//   rise_tick   one-cycle pulse on the edge where clk_out goes 0->1
//   fall_tick   one-cycle pulse on the edge where clk_out goes 1->0
//   div_active  divisor currently in effect
// ---------------------------------------------------------------------------
module clock_divider #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             clk_out,
  output logic             rise_tick,
  output logic             fall_tick,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] MIN_DIV   = WIDTH'(2);
  localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV < 2) ? MIN_DIV : WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] div_reg, div_next;
  logic [WIDTH-1:0] pend_val_reg, pend_val_next;
  logic             pend_reg, pend_next;
  logic             clk_out_reg, clk_out_next;
  logic             rise_reg, rise_next;
  logic             fall_reg, fall_next;

  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] low_len;
  logic             wrap;

  always_comb begin
    // Divisor values 0 and 1 are meaningless; treat them as 2.
    load_val = (div_value < MIN_DIV) ? MIN_DIV : div_value;
    // Low phase gets the extra cycle for odd divisors.
    low_len  = div_reg - (div_reg >> 1);
    // div_reg >= 2, so div_reg-1 cannot underflow, and cnt_reg never
    // exceeds 2^WIDTH-2, so the increment cannot overflow.
    wrap     = (cnt_reg == div_reg - WIDTH'(1));
    cnt_inc  = cnt_reg + WIDTH'(1);

    cnt_next      = cnt_reg;
    div_next      = div_reg;
    pend_val_next = pend_val_reg;
    pend_next     = pend_reg;
    clk_out_next  = clk_out_reg;
    rise_next     = 1'b0;
    fall_next     = 1'b0;

    // Loads are captured regardless of en; the latest request wins.
    if (div_load) begin
      pend_next     = 1'b1;
      pend_val_next = load_val;
    end

    if (en) begin
      if (wrap) begin
        cnt_next     = '0;
        clk_out_next = 1'b0;
        // Period boundary: the only place a new divisor may be applied.
        // A load presented on this very edge is applied immediately.
        if (div_load || pend_reg) begin
          div_next  = div_load ? load_val : pend_val_reg;
          pend_next = 1'b0;
        end
      end else begin
        cnt_next     = cnt_inc;
        clk_out_next = (cnt_inc >= low_len);
      end
      rise_next = !clk_out_reg &&  clk_out_next;
      fall_next =  clk_out_reg && !clk_out_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      div_reg      <= RESET_DIV;
      pend_val_reg <= RESET_DIV;
      pend_reg     <= 1'b0;
      clk_out_reg  <= 1'b0;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      div_reg      <= div_next;
      pend_val_reg <= pend_val_next;
      pend_reg     <= pend_next;
      clk_out_reg  <= clk_out_next;
      rise_reg     <= rise_next;
      fall_reg     <= fall_next;
    end
  end

  assign clk_out    = clk_out_reg;
  assign rise_tick  = rise_reg;
  assign fall_tick  = fall_reg;
  assign div_active = div_reg;

endmodule

// File: tb/tb_clock_divider.sv
// ---------------------------------------------------------------------------
// tb_clock_divider
//   Directed test of clock_divider. A reference model represents each
//   period of clk_out as a queue of output levels (L zeros then H ones). It
//   is consumed one entry per enabled edge and refilled at period
//   boundaries, where pending divisor loads are applied. A compare process
//   checks every DUT output against the model on each falling edge.
//   Literal spot checks pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_clock_divider;

  localparam int WIDTH = 16;
  localparam int DEF   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             clk_out;
  logic             rise_tick;
  logic             fall_tick;
  logic [WIDTH-1:0] div_active;

  int n_checks = 0;
  int n_fail   = 0;

  clock_divider #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div_load   (div_load),
    .div_value  (div_value),
    .clk_out    (clk_out),
    .rise_tick  (rise_tick),
    .fall_tick  (fall_tick),
    .div_active (div_active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit mq[$];
  int m_n;
  bit m_pend;
  int m_pval;
  bit m_prev;
  bit m_valid = 1'b0;
  bit exp_clk, exp_rise, exp_fall;

  function automatic int clamp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  // Queue one full period: low for n-n/2 cycles, high for n/2 cycles.
  task automatic fill_period(input int n, input int skip);
    for (int i = skip; i < n - n / 2; i++) mq.push_back(1'b0);
    for (int i = 0; i < n / 2; i++) mq.push_back(1'b1);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_n    = clamp(DEF);
      m_pend = 1'b0;
      // The reset state itself is the first low cycle of the period.
      fill_period(m_n, 1);
      exp_clk  = 1'b0;
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      m_valid  = 1'b1;
    end else if (en) begin
      m_prev = exp_clk;
      if (mq.size() == 0) begin
        if (div_load) begin
          m_n    = clamp(int'(div_value));
          m_pend = 1'b0;
        end else if (m_pend) begin
          m_n    = m_pval;
          m_pend = 1'b0;
        end
        fill_period(m_n, 0);
      end else if (div_load) begin
        m_pend = 1'b1;
        m_pval = clamp(int'(div_value));
      end
      exp_clk  = mq.pop_front();
      exp_rise = !m_prev && exp_clk;
      exp_fall = m_prev && !exp_clk;
    end else begin
      exp_rise = 1'b0;
      exp_fall = 1'b0;
      if (div_load) begin
        m_pend = 1'b1;
        m_pval = clamp(int'(div_value));
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("clk_out", 32'(clk_out), 32'(exp_clk));
      check("rise_tick", 32'(rise_tick), 32'(exp_rise));
      check("fall_tick", 32'(fall_tick), 32'(exp_fall));
      check("div_active", 32'(div_active), 32'(m_n));
    end
  end

  // ---------------- stimulus ----------------
  // Advance one clock edge; inputs change and spot checks sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic load(input int v);
    div_load  = 1'b1;
    div_value = WIDTH'(v);
    step();
    div_load  = 1'b0;
  endtask

  // Wait (bounded) until the divisor switches; lands on the period start.
  task automatic wait_div(input int target);
    int k = 0;
    while (int'(div_active) != target && k < 40) begin
      step();
      k++;
    end
    check("wait_div", 32'(div_active), 32'(target));
  endtask

  initial begin
    int rc, fc;
    rst = 1'b1; en = 1'b0; div_load = 1'b0; div_value = '0;
    steps(2);
    check("reset_clk_out", 32'(clk_out), 32'd0);
    check("reset_div", 32'(div_active), 32'd2);
    check("reset_ticks", 32'({rise_tick, fall_tick}), 32'd0);
    rst = 1'b0; en = 1'b1;

    // Default divide by 2.
    step();
    $display("default: edge1 clk_out=%0b rise=%0b", clk_out, rise_tick);
    check("def_edge1_clk", 32'(clk_out), 32'd1);
    check("def_edge1_rise", 32'(rise_tick), 32'd1);
    step();
    $display("default: edge2 clk_out=%0b fall=%0b", clk_out, fall_tick);
    check("def_edge2_clk", 32'(clk_out), 32'd0);
    check("def_edge2_fall", 32'(fall_tick), 32'd1);
    steps(4);

    // Odd divisor 5: low 3, high 2.
    load(5);
    steps(3);
    check("odd_div", 32'(div_active), 32'd5);
    rc = 0; fc = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      rc += int'(rise_tick);
      fc += int'(fall_tick);
    end
    $display("odd: rises=%0d falls=%0d in 10 cycles", rc, fc);
    check("odd_rises", 32'(rc), 32'd2);
    check("odd_falls", 32'(fc), 32'd2);

    // Mid-period load: N=4, load 8 while cnt=1.
    load(4);
    wait_div(4);
    step();
    load(8);
    $display("midload: after load edge div=%0d clk_out=%0b", div_active, clk_out);
    check("mid_div_hold", 32'(div_active), 32'd4);
    check("mid_clk_hi", 32'(clk_out), 32'd1);
    steps(2);
    $display("midload: at boundary div=%0d fall=%0b", div_active, fall_tick);
    check("mid_div_new", 32'(div_active), 32'd8);
    check("mid_fall", 32'(fall_tick), 32'd1);
    steps(16);

    // Clamp: 0 and 1 both become 2.
    load(0);
    wait_div(2);
    steps(4);
    load(1);
    steps(6);
    $display("clamp: div=%0d", div_active);
    check("clamp_div", 32'(div_active), 32'd2);

    // Enable hold: N=6, freeze at cnt=4 (mid high phase) for 7 cycles.
    load(6);
    wait_div(6);
    steps(4);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        div_load  = 1'b1;
        div_value = WIDTH'(10);
      end else begin
        div_load = 1'b0;
      end
      step();
      check("hold_clk", 32'(clk_out), 32'd1);
      check("hold_ticks", 32'({rise_tick, fall_tick}), 32'd0);
    end
    div_load = 1'b0;
    en = 1'b1;
    step();
    check("resume_hi", 32'(clk_out), 32'd1);
    step();
    $display("resume: clk_out=%0b fall=%0b div=%0d", clk_out, fall_tick, div_active);
    check("resume_fall", 32'(fall_tick), 32'd1);
    check("resume_div10", 32'(div_active), 32'd10);

    // Reset mid-operation at cnt=7 with a load pending.
    steps(6);
    load(3);
    rst = 1'b1;
    step();
    $display("midreset: clk_out=%0b ticks=%0b%0b div=%0d", clk_out, rise_tick, fall_tick, div_active);
    check("mrst_clk", 32'(clk_out), 32'd0);
    check("mrst_ticks", 32'({rise_tick, fall_tick}), 32'd0);
    check("mrst_div", 32'(div_active), 32'd2);
    rst = 1'b0;
    step();
    check("mrst_edge1", 32'(clk_out), 32'd1);
    steps(8);
    check("mrst_no_pending", 32'(div_active), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
